// File: rtl/pipecleaner_chain.sv
// Valid/ready pipeline of DEPTH stages; each stage applies a tag-selected transform
// carried alongside the data, with flush, freeze, occupancy and a delivered-beat counter.
module pipecleaner_chain #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         ena,
   input  logic                         flush,
   input  logic [1:0]                   mode,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_W-1:0]             beat_count
);

   localparam int OCC_W = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      OP_PASS = 2'd0,
      OP_INC  = 2'd1,
      OP_INV  = 2'd2,
      OP_ROTL = 2'd3
   } op_e;

   function automatic logic [WIDTH-1:0] op(input op_e tag, input logic [WIDTH-1:0] x);
      case (tag)
         OP_PASS: return x;
         OP_INC:  return x + WIDTH'(1);
         OP_INV:  return ~x;
         default: return {x[WIDTH-2:0], x[WIDTH-1]};
      endcase
   endfunction

   logic [DEPTH-1:0] v_q, v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   op_e              t_q [DEPTH];
   op_e              t_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0] rdy;
   logic [OCC_W-1:0] occ;

   // A stage is ready unless it and every stage downstream are full while out_ready is low.
   always_comb begin
      logic full;
      rdy  = '0;
      full = !out_ready;
      for (int i = DEPTH-1; i >= 0; i--) begin
         full   = full & v_q[i];
         rdy[i] = !full;
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) occ = occ + OCC_W'(v_q[i]);
   end

   // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      v_d   = v_q;
      d_d   = d_q;
      t_d   = t_q;
      cnt_d = cnt_q;
      if (ena) begin
         if (flush) begin
            v_d = '0;
         end else begin
            if (rdy[0]) begin
               v_d[0] = in_valid;
               if (in_valid) begin
                  d_d[0] = op(op_e'(mode), in_data);
                  t_d[0] = op_e'(mode);
               end
            end
            for (int i = 1; i < DEPTH; i++) begin
               if (rdy[i]) begin
                  v_d[i] = v_q[i-1];
                  if (v_q[i-1]) begin
                     d_d[i] = op(t_q[i-1], d_q[i-1]);
                     t_d[i] = t_q[i-1];
                  end
               end
            end
            if (v_q[DEPTH-1] && out_ready) cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // NOTE: data/tag registers are reset too so out_data reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q   <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= '0;
            t_q[i] <= OP_PASS;
         end
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         v_q   <= v_d;
         d_q   <= d_d;
         t_q   <= t_d;
         cnt_q <= cnt_d;
      end
   end

   assign in_ready   = rst_n & ena & !flush & rdy[0];
   assign out_valid  = ena & v_q[DEPTH-1];
   assign out_data   = d_q[DEPTH-1];
   assign occupancy  = occ;
   assign beat_count = cnt_q;

endmodule
